mux_channel_scanner: RTL and testbench

- Upstream sequencer for the existing 4:1 mux (selects s1/s0, data inputs a..d, output y). On a start request it steps the mux select through channels 0..3 and waits a programmable settle time on each channel.
- It samples the mux output for every channel and presents the four samples as one 4-bit word, with a done pulse and a changed flag.
- It sits between control logic, which issues start and continuous, and the mux, whose select lines it drives and whose output it reads.

---
 rtl/mux_channel_scanner_pkg.sv | 20 ++
 rtl/scan_settle_timer.sv | 31 +++
 rtl/mux_channel_scanner.sv | 95 +++++++++
 tb/tb_mux_channel_scanner.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_channel_scanner_pkg.sv
// Shared constants and types for the 4:1 mux channel scanner.
// Pure declarations, no logic, so there is no latency.
// Backpressure does not apply to this file.
package mux_scan_pkg;

  localparam int N_CH     = 4;
  localparam int SEL_W    = 2;
  localparam int SETTLE_W = 4;

  typedef enum logic {
    IDLE,
    WAIT
  } scan_state_t;

  typedef logic [SEL_W-1:0] ch_t;

  // Highest channel index; reaching it ends a scan.
  localparam ch_t LAST_CH = ch_t'(N_CH - 1);

endpackage

// File: rtl/scan_settle_timer.sv
// Settle timer: counts the cycles one mux select value has been held.
// expire is high in the cycle whose closing edge is the SETTLE-th edge of the hold.
// No backpressure: it counts whenever en is high and restarts on clr.
module scan_settle_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [SETTLE_W-1:0] LAST = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] cnt;

  assign expire = en && (cnt == LAST);

  // Count while enabled; wrap to zero on expiry so the next channel starts fresh.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= expire ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_channel_scanner.sv
// Steps a 4:1 mux through channels 0..3, samples y after SETTLE cycles each, emits a 4-bit word.
// Latency: 4*SETTLE cycles from the edge accepting start to the done pulse.
// No backpressure: start is ignored while busy; continuous chains scans with no gap.
module mux_channel_scanner
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic       mux_y,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] data,
  output logic       changed
);

  scan_state_t         state;
  ch_t                 ch;
  ch_t                 sel;
  logic [N_CH-2:0]     work;
  logic                expire;
  logic                timer_clr;

  assign s0 = sel[0];
  assign s1 = sel[1];

  // Restart the settle count whenever a scan is launched from IDLE.
  assign timer_clr = (state == IDLE) && start;

  scan_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (state == WAIT),
    .expire (expire)
  );

  // Scan sequencer: launch, capture per channel, publish the word on the last channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      sel     <= '0;
      work    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      data    <= '0;
      changed <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT;
            ch    <= '0;
            sel   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (expire) begin
            if (ch != LAST_CH) begin
              work[ch] <= mux_y;
              ch       <= ch + ch_t'(1);
              sel      <= ch + ch_t'(1);
            end else begin
              // Completion: the last sample goes straight into the published word.
              data    <= {mux_y, work};
              changed <= ({mux_y, work} != data);
              done    <= 1'b1;
              ch      <= '0;
              sel     <= '0;
              if (!continuous) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Self-checking bench for mux_channel_scanner driving a behavioural 4:1 mux.
// Expected words come from a scan model: bit k is the mux input k present at capture edge k.
// Runs with SETTLE=2.
module tb_mux_channel_scanner;

  localparam int ST = 2;
  localparam int SCAN = 4 * ST;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       continuous;
  logic [3:0] ins;          // ins[0]=a, ins[1]=b, ins[2]=c, ins[3]=d
  logic       mux_y;
  logic       s0, s1, busy, done, changed;
  logic [3:0] data;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [3:0] model_data;   // last word the scanner should have published

  always #5 clk = ~clk;

  // Behavioural stand-in for the existing 4:1 mux.
  assign mux_y = ins[{s1, s0}];

  mux_channel_scanner #(
    .SETTLE (ST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .mux_y      (mux_y),
    .s0         (s0),
    .s1         (s1),
    .busy       (busy),
    .done       (done),
    .data       (data),
    .changed    (changed)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive start so it is sampled at the next edge (E0); returns just after E0.
  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; ins = 4'($urandom);
    tick(); tick();
    n_cmp += 6;
    if ({s1, s0} !== 2'b00) begin n_fail++; $display("FAIL reset_sel got=%b want=00", {s1, s0}); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    if (data !== 4'b0000)   begin n_fail++; $display("FAIL reset_data got=%b want=0000", data); end
    if (changed !== 1'b0)   begin n_fail++; $display("FAIL reset_changed got=%b want=0", changed); end
    rst = 1'b0;
    tick();
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    model_data = 4'b0000;
  endtask

  task automatic test_single;
    logic [1:0] esel;
    ins = 4'b0100;
    pulse_start();
    for (int t = 0; t <= SCAN; t++) begin
      if (t > 0) tick();
      esel = (t < SCAN) ? 2'(t / ST) : 2'b00;
      n_cmp += 4;
      if ({s1, s0} !== esel)       begin n_fail++; $display("FAIL single_sel t=%0d got=%b want=%b", t, {s1, s0}, esel); end
      if (busy !== (t < SCAN))     begin n_fail++; $display("FAIL single_busy t=%0d got=%b want=%b", t, busy, t < SCAN); end
      if (done !== (t == SCAN))    begin n_fail++; $display("FAIL single_done t=%0d got=%b want=%b", t, done, t == SCAN); end
      if (data !== ((t < SCAN) ? model_data : 4'b0100)) begin
        n_fail++; $display("FAIL single_data t=%0d got=%b", t, data);
      end
    end
    n_cmp++;
    if (changed !== (4'b0100 != model_data)) begin n_fail++; $display("FAIL single_changed got=%b want=1", changed); end
    model_data = 4'b0100;
    tick();
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width got=%b want=0", done); end
  endtask

  task automatic test_repeat;
    logic [3:0] pats [2];
    int         lat;
    pats[0] = 4'b0100;
    pats[1] = 4'b1100;
    for (int p = 0; p < 2; p++) begin
      ins = pats[p];
      pulse_start();
      lat = 0;
      while (done !== 1'b1 && lat < 3 * SCAN) begin
        tick();
        lat++;
      end
      n_cmp += 3;
      if (lat !== SCAN)     begin n_fail++; $display("FAIL repeat_latency p=%0d got=%0d want=%0d", p, lat, SCAN); end
      if (data !== pats[p]) begin n_fail++; $display("FAIL repeat_data p=%0d got=%b want=%b", p, data, pats[p]); end
      if (changed !== (pats[p] != model_data)) begin
        n_fail++; $display("FAIL repeat_changed p=%0d got=%b want=%b", p, changed, pats[p] != model_data);
      end
      model_data = pats[p];
      tick();
    end
  endtask

  task automatic test_start_ignored;
    int dones;
    logic [3:0] pat;
    pat = 4'($urandom);
    ins = pat;
    dones = 0;
    pulse_start();
    for (int t = 1; t <= 2 * SCAN; t++) begin
      if (t == 3) start = 1'b1;
      tick();
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (t < SCAN) begin
        n_cmp++;
        if ({s1, s0} !== 2'(t / ST)) begin n_fail++; $display("FAIL ignored_sel t=%0d got=%b want=%b", t, {s1, s0}, 2'(t / ST)); end
      end
      if (t == SCAN) begin
        n_cmp += 2;
        if (data !== pat) begin n_fail++; $display("FAIL ignored_data got=%b want=%b", data, pat); end
        if (changed !== (pat != model_data)) begin n_fail++; $display("FAIL ignored_changed got=%b want=%b", changed, pat != model_data); end
        model_data = pat;
      end
    end
    n_cmp += 2;
    if (dones !== 1)   begin n_fail++; $display("FAIL ignored_done_count got=%0d want=1", dones); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_continuous;
    int extra;
    continuous = 1'b1;
    ins = 4'b1101;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      for (int t = 1; t <= SCAN; t++) begin
        if (k == 2 && t == 4) continuous = 1'b0;
        tick();
        n_cmp += 2;
        if (done !== (t == SCAN)) begin n_fail++; $display("FAIL cont_done k=%0d t=%0d got=%b", k, t, done); end
        if (busy !== !(k == 2 && t == SCAN)) begin n_fail++; $display("FAIL cont_busy k=%0d t=%0d got=%b", k, t, busy); end
        if (t < SCAN) begin
          n_cmp++;
          if ({s1, s0} !== 2'(t / ST)) begin n_fail++; $display("FAIL cont_sel k=%0d t=%0d got=%b", k, t, {s1, s0}); end
        end
      end
      n_cmp += 2;
      if (data !== 4'b1101) begin n_fail++; $display("FAIL cont_data k=%0d got=%b want=1101", k, data); end
      if (changed !== (4'b1101 != model_data)) begin n_fail++; $display("FAIL cont_changed k=%0d got=%b", k, changed); end
      model_data = 4'b1101;
    end
    extra = 0;
    for (int t = 0; t < 2 * SCAN; t++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_fail++; $display("FAIL cont_stop got=%0d active cycles want=0", extra); end
  endtask

  task automatic test_reset_mid;
    int dones;
    int lat;
    logic [3:0] pat;
    pat = 4'($urandom) | 4'b0001;
    ins = pat;
    pulse_start();
    for (int t = 1; t <= 4; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_data = 4'b0000;
    n_cmp += 4;
    if ({s1, s0} !== 2'b00) begin n_fail++; $display("FAIL midrst_sel got=%b want=00", {s1, s0}); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy got=%b want=0", busy); end
    if (data !== 4'b0000)   begin n_fail++; $display("FAIL midrst_data got=%b want=0000", data); end
    if (changed !== 1'b0)   begin n_fail++; $display("FAIL midrst_changed got=%b want=0", changed); end
    dones = 0;
    for (int t = 0; t < 2 * SCAN; t++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d want=0", dones); end
    pulse_start();
    lat = 0;
    while (done !== 1'b1 && lat < 3 * SCAN) begin
      tick();
      lat++;
    end
    n_cmp += 3;
    if (lat !== SCAN)   begin n_fail++; $display("FAIL midrst_restart_latency got=%0d want=%0d", lat, SCAN); end
    if (data !== pat)   begin n_fail++; $display("FAIL midrst_restart_data got=%b want=%b", data, pat); end
    if (changed !== 1'b1) begin n_fail++; $display("FAIL midrst_restart_changed got=%b want=1", changed); end
    model_data = pat;
    tick();
  endtask

  // Inputs change every cycle; the model keeps whatever input k held at channel k's capture edge.
  task automatic test_random;
    logic [3:0] expw;
    int gap;
    for (int s = 0; s < 25; s++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      expw = 4'b0000;
      ins = 4'($urandom);
      pulse_start();
      for (int t = 1; t <= SCAN; t++) begin
        ins = 4'($urandom);
        if (t % ST == 0) expw[t / ST - 1] = ins[t / ST - 1];
        tick();
        if (t < SCAN) begin
          n_cmp++;
          if (done !== 1'b0) begin n_fail++; $display("FAIL rand_early_done s=%0d t=%0d", s, t); end
        end
      end
      n_cmp += 3;
      if (done !== 1'b1) begin n_fail++; $display("FAIL rand_done s=%0d got=%b want=1", s, done); end
      if (data !== expw) begin n_fail++; $display("FAIL rand_data s=%0d got=%b want=%b", s, data, expw); end
      if (changed !== (expw != model_data)) begin
        n_fail++; $display("FAIL rand_changed s=%0d got=%b want=%b", s, changed, expw != model_data);
      end
      model_data = expw;
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; ins = 4'b0000;
    model_data = 4'b0000;
    test_reset();
    test_single();
    test_repeat();
    test_start_ignored();
    test_continuous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
